// File: rtl/uart_alu_sequencer_pkg.sv
// Shared definitions for the UART/ALU sequencer: opcode constants (also used by the ALU),
// FSM state encoding and the opcode validity helper.
package uart_alu_sequencer_pkg;

    localparam int N_BITS_OP_DEFAULT = 6;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    function automatic logic isValidOp(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_alu_sequencer_if.sv
// Bundle of the receiver, transmitter and ALU signals seen by the sequencer.
// The slave modport is the sequencer side; master is the surrounding UART/ALU side.
interface uart_alu_sequencer_if #(
    parameter int N_BITS_DATA = 8,
    parameter int N_BITS_OP   = uart_alu_sequencer_pkg::N_BITS_OP_DEFAULT
);

    logic                   rx_done_tick_i;
    logic [N_BITS_DATA-1:0] rx_data_i;
    logic                   tx_done_tick_i;
    logic [N_BITS_DATA-1:0] alu_result_i;
    logic [N_BITS_DATA-1:0] alu_a_o;
    logic [N_BITS_DATA-1:0] alu_b_o;
    logic [N_BITS_OP-1:0]   alu_op_o;
    logic [N_BITS_DATA-1:0] tx_data_o;
    logic                   tx_start_o;
    logic                   busy_o;
    logic                   err_op_o;
    logic                   err_ovr_o;
    logic                   err_tmo_o;

    modport slave (
        input  rx_done_tick_i, rx_data_i, tx_done_tick_i, alu_result_i,
        output alu_a_o, alu_b_o, alu_op_o, tx_data_o, tx_start_o,
               busy_o, err_op_o, err_ovr_o, err_tmo_o
    );

    modport master (
        output rx_done_tick_i, rx_data_i, tx_done_tick_i, alu_result_i,
        input  alu_a_o, alu_b_o, alu_op_o, tx_data_o, tx_start_o,
               busy_o, err_op_o, err_ovr_o, err_tmo_o
    );

endinterface

// File: rtl/uart_alu_sequencer_timeout.sv
// Inter-byte timeout counter. Saturating; a TIMEOUT_CYCLES of 0 never expires,
// so the FSM does not need to know about the disabled case.
module byte_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [W-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? W'(TIMEOUT_CYCLES - 1) : '0;

    logic [W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES > 0) && enable && (r_count == LIMIT);

endmodule

// File: rtl/uart_alu_sequencer.sv
// Sequencer between UART rx/tx and the ALU: collects A, B, opcode, runs the ALU,
// sends the result, and flags bad opcodes, overruns and inter-byte timeouts.
module uart_alu_sequencer
    import uart_alu_sequencer_pkg::*;
#(
    parameter int N_BITS_DATA    = 8,
    parameter int N_BITS_OP      = N_BITS_OP_DEFAULT,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                 clock,
    input  logic                 reset,
    uart_alu_sequencer_if.slave  bus
);

    state_t                 r_state;
    logic [N_BITS_DATA-1:0] r_alu_a;
    logic [N_BITS_DATA-1:0] r_alu_b;
    logic [N_BITS_OP-1:0]   r_alu_op;
    logic [N_BITS_DATA-1:0] r_tx_data;
    logic                   r_tx_start;
    logic                   r_busy;
    logic                   r_err_op;
    logic                   r_err_ovr;
    logic                   r_err_tmo;

    logic w_rx_tick;
    logic w_op_valid;
    logic w_tmo_enable;
    logic w_tmo_clear;
    logic w_tmo_expired;

    assign w_rx_tick  = bus.rx_done_tick_i;
    assign w_op_valid = (bus.rx_data_i[N_BITS_DATA-1:N_BITS_OP] == '0)
                     && isValidOp(6'(bus.rx_data_i[N_BITS_OP-1:0]));

    // The counter only runs while a frame is partially collected; any accepted byte restarts it.
    assign w_tmo_enable = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
    assign w_tmo_clear  = !w_tmo_enable || w_rx_tick;

    byte_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (w_tmo_clear),
        .enable (w_tmo_enable),
        .expired(w_tmo_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_WAIT_A;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_err_op   <= 1'b0;
            r_err_ovr  <= 1'b0;
            r_err_tmo  <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_err_op   <= 1'b0;
            r_err_ovr  <= 1'b0;
            r_err_tmo  <= 1'b0;
            case (r_state)
                ST_WAIT_A: begin
                    if (w_rx_tick) begin
                        r_alu_a <= bus.rx_data_i;
                        r_state <= ST_WAIT_B;
                        r_busy  <= 1'b1;
                    end
                end
                ST_WAIT_B: begin
                    if (w_rx_tick) begin
                        r_alu_b <= bus.rx_data_i;
                        r_state <= ST_WAIT_OP;
                    end else if (w_tmo_expired) begin
                        r_err_tmo <= 1'b1;
                        r_state   <= ST_WAIT_A;
                        r_busy    <= 1'b0;
                    end
                end
                ST_WAIT_OP: begin
                    if (w_rx_tick) begin
                        if (w_op_valid) begin
                            r_alu_op <= bus.rx_data_i[N_BITS_OP-1:0];
                            r_state  <= ST_EXEC;
                        end else begin
                            r_err_op <= 1'b1;
                            r_state  <= ST_WAIT_A;
                            r_busy   <= 1'b0;
                        end
                    end else if (w_tmo_expired) begin
                        r_err_tmo <= 1'b1;
                        r_state   <= ST_WAIT_A;
                        r_busy    <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    r_tx_data  <= bus.alu_result_i;
                    r_tx_start <= 1'b1;
                    r_err_ovr  <= w_rx_tick;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    r_err_ovr <= w_rx_tick;
                    r_state   <= ST_WAIT_TX;
                end
                // A byte arriving here is dropped even if the transmit completes in the same cycle.
                ST_WAIT_TX: begin
                    r_err_ovr <= w_rx_tick;
                    if (bus.tx_done_tick_i) begin
                        r_state <= ST_WAIT_A;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_WAIT_A;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alu_a_o    = r_alu_a;
    assign bus.alu_b_o    = r_alu_b;
    assign bus.alu_op_o   = r_alu_op;
    assign bus.tx_data_o  = r_tx_data;
    assign bus.tx_start_o = r_tx_start;
    assign bus.busy_o     = r_busy;
    assign bus.err_op_o   = r_err_op;
    assign bus.err_ovr_o  = r_err_ovr;
    assign bus.err_tmo_o  = r_err_tmo;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Scoreboard bench for uart_alu_sequencer: directed frames push expected events,
// a negedge monitor pops and compares every tx_start / error pulse.
module tb_uart_alu_sequencer;
    import uart_alu_sequencer_pkg::*;

    typedef enum int {EV_TX = 0, EV_OP = 1, EV_OVR = 2, EV_TMO = 3} evKind_t;
    typedef struct {
        evKind_t    kind;
        logic [7:0] data;
    } expEvent_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    expEvent_t expQ[$];

    uart_alu_sequencer_if #(.N_BITS_DATA(8), .N_BITS_OP(6)) bus();

    uart_alu_sequencer #(
        .N_BITS_DATA   (8),
        .N_BITS_OP     (6),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Behavioural ALU closing the loop from the registered operands
    always_comb begin
        bus.alu_result_i = 8'h00;
        case (bus.alu_op_o)
            OP_ADD:  bus.alu_result_i = bus.alu_a_o + bus.alu_b_o;
            OP_SUB:  bus.alu_result_i = bus.alu_a_o - bus.alu_b_o;
            OP_AND:  bus.alu_result_i = bus.alu_a_o & bus.alu_b_o;
            OP_OR:   bus.alu_result_i = bus.alu_a_o | bus.alu_b_o;
            OP_XOR:  bus.alu_result_i = bus.alu_a_o ^ bus.alu_b_o;
            OP_NOR:  bus.alu_result_i = ~(bus.alu_a_o | bus.alu_b_o);
            OP_SRA:  bus.alu_result_i = $signed(bus.alu_a_o) >>> bus.alu_b_o;
            OP_SRL:  bus.alu_result_i = bus.alu_a_o >> bus.alu_b_o;
            default: bus.alu_result_i = 8'h00;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic expectEvent(input evKind_t kind, input logic [7:0] data);
        expEvent_t e;
        e.kind = kind;
        e.data = data;
        expQ.push_back(e);
    endtask

    task automatic popCheck(input evKind_t kind, input logic [7:0] data);
        expEvent_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_event: got kind %0d, expected none at %0t", int'(kind), $time);
        end else begin
            e = expQ.pop_front();
            checkOutput("event_kind", 32'(kind), 32'(e.kind));
            if (kind == EV_TX) checkOutput("tx_data", 32'(data), 32'(e.data));
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.tx_start_o) popCheck(EV_TX, bus.tx_data_o);
            if (bus.err_op_o)   popCheck(EV_OP, 8'h00);
            if (bus.err_ovr_o)  popCheck(EV_OVR, 8'h00);
            if (bus.err_tmo_o)  popCheck(EV_TMO, 8'h00);
        end
    end

    // Called just after a rising edge; the byte is sampled on the next one
    task automatic applyStimulus(input logic [7:0] b);
        bus.rx_done_tick_i = 1'b1;
        bus.rx_data_i      = b;
        @(posedge clock);
        #1;
        bus.rx_done_tick_i = 1'b0;
        bus.rx_data_i      = 8'h00;
    endtask

    task automatic finishFrame(input logic [7:0] a, input logic [7:0] b);
        @(negedge clock);
        checkOutput("start_in_exec", 32'(bus.tx_start_o), 32'd0);
        checkOutput("busy_in_exec", 32'(bus.busy_o), 32'd1);
        @(negedge clock);
        checkOutput("start_in_send", 32'(bus.tx_start_o), 32'd1);
        checkOutput("alu_a", 32'(bus.alu_a_o), 32'(a));
        checkOutput("alu_b", 32'(bus.alu_b_o), 32'(b));
    endtask

    task automatic txDone();
        @(posedge clock);
        #1;
        bus.tx_done_tick_i = 1'b1;
        @(posedge clock);
        #1;
        bus.tx_done_tick_i = 1'b0;
        @(negedge clock);
        checkOutput("busy_after_done", 32'(bus.busy_o), 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic sendFrame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input logic [7:0] result);
        expectEvent(EV_TX, result);
        applyStimulus(a);
        applyStimulus(b);
        applyStimulus(op);
        finishFrame(a, b);
        txDone();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic sawEarly;
        bus.rx_done_tick_i = 1'b0;
        bus.rx_data_i      = 8'h00;
        bus.tx_done_tick_i = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_alu_a", 32'(bus.alu_a_o), 32'd0);
        checkOutput("rst_alu_b", 32'(bus.alu_b_o), 32'd0);
        checkOutput("rst_alu_op", 32'(bus.alu_op_o), 32'd0);
        checkOutput("rst_tx_data", 32'(bus.tx_data_o), 32'd0);
        checkOutput("rst_tx_start", 32'(bus.tx_start_o), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("rst_errs", 32'({bus.err_op_o, bus.err_ovr_o, bus.err_tmo_o}), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        $display("[TB] basic frames");
        sendFrame(8'h05, 8'h03, 8'h20, 8'h08);
        sendFrame(8'h0F, 8'hF0, 8'h27, 8'h00);
        sendFrame(8'h80, 8'h01, 8'h03, 8'hC0);
        checkOutput("op_sra", 32'(bus.alu_op_o), 32'h03);

        $display("[TB] invalid opcodes");
        expectEvent(EV_OP, 8'h00);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h21);
        @(negedge clock);
        checkOutput("busy_bad_op", 32'(bus.busy_o), 32'd0);
        checkOutput("op_kept_21", 32'(bus.alu_op_o), 32'h03);
        @(posedge clock);
        #1;
        expectEvent(EV_OP, 8'h00);
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        applyStimulus(8'h60);
        @(negedge clock);
        checkOutput("op_kept_60", 32'(bus.alu_op_o), 32'h03);
        checkOutput("start_bad_op", 32'(bus.tx_start_o), 32'd0);
        @(posedge clock);
        #1;
        sendFrame(8'h07, 8'h02, 8'h22, 8'h05);

        $display("[TB] timeout");
        expectEvent(EV_TMO, 8'h00);
        applyStimulus(8'h01);
        sawEarly = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            sawEarly = sawEarly | bus.err_tmo_o;
        end
        checkOutput("tmo_not_early", 32'(sawEarly), 32'd0);
        @(negedge clock);
        checkOutput("tmo_pulse", 32'(bus.err_tmo_o), 32'd1);
        checkOutput("busy_after_tmo", 32'(bus.busy_o), 32'd0);
        @(posedge clock);
        #1;

        $display("[TB] byte on expiry cycle");
        expectEvent(EV_TX, 8'h03);
        applyStimulus(8'h01);
        repeat (15) @(posedge clock);
        #1;
        applyStimulus(8'h02);
        @(negedge clock);
        checkOutput("tmo_suppressed", 32'(bus.err_tmo_o), 32'd0);
        checkOutput("busy_after_late_b", 32'(bus.busy_o), 32'd1);
        @(posedge clock);
        #1;
        applyStimulus(8'h20);
        finishFrame(8'h01, 8'h02);
        txDone();

        $display("[TB] overrun");
        expectEvent(EV_TX, 8'h08);
        applyStimulus(8'h05);
        applyStimulus(8'h03);
        applyStimulus(8'h20);
        finishFrame(8'h05, 8'h03);
        @(posedge clock);
        #1;
        expectEvent(EV_OVR, 8'h00);
        applyStimulus(8'h77);
        @(negedge clock);
        checkOutput("ovr_tx_data", 32'(bus.tx_data_o), 32'h08);
        checkOutput("ovr_busy", 32'(bus.busy_o), 32'd1);
        @(posedge clock);
        #1;
        expectEvent(EV_OVR, 8'h00);
        bus.rx_done_tick_i = 1'b1;
        bus.rx_data_i      = 8'h99;
        bus.tx_done_tick_i = 1'b1;
        @(posedge clock);
        #1;
        bus.rx_done_tick_i = 1'b0;
        bus.rx_data_i      = 8'h00;
        bus.tx_done_tick_i = 1'b0;
        @(negedge clock);
        checkOutput("ovr_done_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("ovr_byte_dropped", 32'(bus.alu_a_o), 32'h05);
        @(posedge clock);
        #1;
        sendFrame(8'h0C, 8'h0A, 8'h24, 8'h08);

        $display("[TB] reset during send");
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        applyStimulus(8'h25);
        @(negedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checkOutput("rs_tx_start", 32'(bus.tx_start_o), 32'd0);
        checkOutput("rs_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("rs_alu_a", 32'(bus.alu_a_o), 32'd0);
        checkOutput("rs_alu_op", 32'(bus.alu_op_o), 32'd0);
        checkOutput("rs_tx_data", 32'(bus.tx_data_o), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (4) @(negedge clock);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
